// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter, LSB first, idle-high line. Bit period is
//               derived from the receiver's oversampling divider so both ends
//               agree on the bit time to the exact clock. Byte input uses a
//               valid/ready handshake.
//               Optional macro UART_TX_HOLD_EN adds a one-byte holding
//               register so the next byte can be accepted mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DIV_SAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int c_DIV_COUNTER = CLK_FREQ / (BAUD_RATE * DIV_SAMPLE);
    localparam int c_BIT_CLKS    = c_DIV_COUNTER * DIV_SAMPLE;
    localparam int c_TOTAL_BITS  = 10;
    localparam int c_CW          = (c_BIT_CLKS > 1) ? $clog2(c_BIT_CLKS) : 1;
    localparam int c_BW          = $clog2(c_TOTAL_BITS);

    localparam logic [c_CW-1:0] c_LAST_CYCLE    = c_CW'(c_BIT_CLKS - 1);
    // Bit index 8 is the last data bit (0 = start, 1..8 = data, 9 = stop)
    localparam logic [c_BW-1:0] c_LAST_DATA_BIT = c_BW'(8);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_CW-1:0] r_cycle_cnt;
    logic [c_BW-1:0] r_bit_cnt;
    logic [9:0]      r_shift;

    logic            w_last_bit;
    logic            w_last_stop;
    logic            w_ready;
    logic            w_accept;
    logic            w_start;
    logic [7:0]      w_frame_byte;

`ifdef UART_TX_HOLD_EN
    logic [7:0]      r_hold;
    logic            r_hold_full;
    logic            w_hold_load;
`endif

    // Handshake decode: when a new frame starts and which byte it carries
    always_comb begin
        w_last_bit   = (r_cycle_cnt == c_LAST_CYCLE);
        w_last_stop  = (r_state == c_ST_STOP) && w_last_bit;
        w_start      = 1'b0;
        w_frame_byte = tx_data;
`ifdef UART_TX_HOLD_EN
        // The final stop cycle also opens the door so a refill can coincide
        // with the hold-to-shift transfer.
        w_ready      = !r_hold_full || w_last_stop;
        w_accept     = tx_valid && w_ready;
        w_hold_load  = 1'b0;
        if (w_last_stop && r_hold_full) begin
            w_start      = 1'b1;
            w_frame_byte = r_hold;
            w_hold_load  = w_accept;
        end else if (((r_state == c_ST_IDLE) || w_last_stop) && w_accept) begin
            w_start = 1'b1;
        end else begin
            w_hold_load = w_accept;
        end
`else
        w_ready  = (r_state == c_ST_IDLE) || w_last_stop;
        w_accept = tx_valid && w_ready;
        w_start  = w_accept;
`endif
    end

    // Next-state logic for the frame sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start) w_state_next = c_ST_START;
            c_ST_START: if (w_last_bit) w_state_next = c_ST_DATA;
            c_ST_DATA:  if (w_last_bit && (r_bit_cnt == c_LAST_DATA_BIT)) w_state_next = c_ST_STOP;
            c_ST_STOP:  if (w_last_bit) w_state_next = w_start ? c_ST_START : c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Bit timing counters and shift register; bit 0 of the shifter drives TxD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '1;
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
        end else if (w_start) begin
            r_shift     <= {1'b1, w_frame_byte, 1'b0};
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
        end else if (r_state != c_ST_IDLE) begin
            if (w_last_bit) begin
                // Ones shift in from the top so the line idles high afterwards
                r_shift     <= {1'b1, r_shift[9:1]};
                r_cycle_cnt <= '0;
                r_bit_cnt   <= w_last_stop ? '0 : r_bit_cnt + 1'b1;
            end else begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_HOLD_EN
    // Holding register: filled by a mid-frame accept, drained at frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_hold_load) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end else if (w_last_stop) begin
            r_hold_full <= 1'b0;
        end
    end
`endif

    assign tx_ready = w_ready;
    assign TxD      = r_shift[0];
    assign tx_busy  = (r_state != c_ST_IDLE);
    assign tx_done  = w_last_stop;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter. Table vectors plus
//               random bytes, checked against a frame model and a behavioural
//               mid-bit sampling receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    localparam int CLK_FREQ   = 50_000_000;
    localparam int BAUD_RATE  = 115200;
    localparam int DIV_SAMPLE = 16;
    localparam int BIT_CLKS   = (CLK_FREQ / (BAUD_RATE * DIV_SAMPLE)) * DIV_SAMPLE;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    wire        tx_ready;
    wire        TxD;
    wire        tx_busy;
    wire        tx_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_frames[$];
    logic [7:0] exp_bytes[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    uart_transmitter #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DIV_SAMPLE(DIV_SAMPLE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .TxD     (TxD),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line level for each bit position of a frame, from the 8N1 rules
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      f[i] = 1'b0;
            else if (i == 9) f[i] = 1'b1;
            else             f[i] = 1'((int'(b) / (1 << (i - 1))) % 2);
        end
        return f;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) return;
        end
        check("wait_ready timeout", 0, 1);
    endtask

    // One-cycle valid pulse; returns just after the accepting edge
    task automatic accept(input logic [7:0] b);
        wait_ready();
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Watch nframes consecutive frames starting the cycle after an accept
    task automatic monitor(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            logic [9:0] frame;
            logic [7:0] eb;
            logic [7:0] rx;
            int done_cnt, done_bad, busy_bad;
            frame = exp_frames.pop_front();
            eb    = exp_bytes.pop_front();
            rx = '0; done_cnt = 0; done_bad = 0; busy_bad = 0;
            for (int b = 0; b < 10; b++) begin
                int bit_bad;
                bit_bad = 0;
                for (int k = 0; k < BIT_CLKS; k++) begin
                    @(negedge clk);
                    if (TxD !== frame[b]) bit_bad++;
                    if ((k == BIT_CLKS / 2) && (b >= 1) && (b <= 8)) rx[b-1] = TxD;
                    if (tx_done === 1'b1) done_cnt++;
                    if (tx_done !== ((b == 9) && (k == BIT_CLKS - 1))) done_bad++;
                    if (tx_busy !== 1'b1) busy_bad++;
                end
                check($sformatf("frame %0d bit %0d wrong cycles", f, b), bit_bad, 0);
            end
            check($sformatf("rx byte frame %0d", f), int'(rx), int'(eb));
            check($sformatf("done pulses frame %0d", f), done_cnt, 1);
            check($sformatf("done timing frame %0d", f), done_bad, 0);
            check($sformatf("busy frame %0d", f), busy_bad, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " TxD"},      int'(TxD),      1);
        check({tag, " tx_ready"}, int'(tx_ready), 1);
        check({tag, " tx_busy"},  int'(tx_busy),  0);
        check({tag, " tx_done"},  int'(tx_done),  0);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h55, frame: 10'b1010101010};
        vecs[4] = '{data: 8'h3C, frame: 10'b1001111000};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2;
        check_reset_outputs("power-on reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset asserted mid-cycle during a start bit acts with no clock edge
        accept(8'hC3);
        repeat (100) @(negedge clk);
        check("pre-reset start bit TxD", int'(TxD), 0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        reset = 1'b0;

        // Table vectors: A5 first, then the loopback set
        for (int i = 0; i < 5; i++) begin
            exp_frames.push_back(vecs[i].frame);
            exp_bytes.push_back(vecs[i].data);
            accept(vecs[i].data);
            monitor(1);
        end

        // Busy protection: a mid-frame pulse must not disturb the frame
        exp_frames.push_back(model_frame(8'h12));
        exp_bytes.push_back(8'h12);
`ifdef UART_TX_HOLD_EN
        exp_frames.push_back(model_frame(8'h34));
        exp_bytes.push_back(8'h34);
`endif
        accept(8'h12);
        fork
`ifdef UART_TX_HOLD_EN
            monitor(2);
`else
            monitor(1);
`endif
            begin
                repeat (1000) @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = 8'h34;
`ifdef UART_TX_HOLD_EN
                check("ready during frame", int'(tx_ready), 1);
`else
                check("ready during frame", int'(tx_ready), 0);
`endif
                repeat (5) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if ((TxD !== 1'b1) || (tx_busy !== 1'b0)) bad++;
            end
            check("idle after busy test", bad, 0);
        end

        // Back-to-back with valid held high
        exp_frames.push_back(model_frame(8'h01));
        exp_bytes.push_back(8'h01);
        exp_frames.push_back(model_frame(8'h02));
        exp_bytes.push_back(8'h02);
        wait_ready();
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        @(posedge clk);
        fork
            monitor(2);
            begin
                #1 tx_data = 8'h02;
`ifdef UART_TX_HOLD_EN
                @(posedge clk);
                #1 tx_valid = 1'b0;
                check("hold full blocks ready", int'(tx_ready), 0);
`else
                repeat (FRAME_CLKS) @(posedge clk);
                #1 tx_valid = 1'b0;
`endif
            end
        join

        // Reset during data bit 3 of 0x0F, then a clean 0x81 frame
        accept(8'h0F);
        repeat (4 * BIT_CLKS + 200) @(negedge clk);
        check("pre-reset busy", int'(tx_busy), 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid-frame reset");
        @(negedge clk);
        reset = 1'b0;
        exp_frames.push_back(model_frame(8'h81));
        exp_bytes.push_back(8'h81);
        accept(8'h81);
        monitor(1);

        // Random bytes with random idle gaps
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            exp_frames.push_back(model_frame(b));
            exp_bytes.push_back(b);
            accept(b);
            monitor(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
